// File: rtl/ir_fetch_if.sv
// Bus bundle between the fetch sequencer, program memory, the IR and the decoder.
// master = ir_fetch side; slave = memory/IR/decoder side.
interface ir_fetch_if #(
  parameter int AW = 8,
  parameter int DW = 18
);
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_data;
  logic          wr_IR;
  logic          re_IR;
  logic [DW-1:0] IRin;
  logic          ir_valid;
  logic          dec_ready;
  logic          pc_load;
  logic [AW-1:0] pc_load_val;

  modport master (
    output mem_rd, mem_addr, wr_IR, re_IR, IRin, ir_valid,
    input  mem_ack, mem_data, dec_ready, pc_load, pc_load_val
  );

  modport slave (
    input  mem_rd, mem_addr, wr_IR, re_IR, IRin, ir_valid,
    output mem_ack, mem_data, dec_ready, pc_load, pc_load_val
  );
endinterface

// File: rtl/ir_fetch.sv
// Instruction fetch sequencer: PC, memory read, IR write/read strobes, decoder handshake.
// Optional memory-ack timeout with sticky fetch_err under macro IR_FETCH_TIMEOUT_EN.
module ir_fetch #(
  parameter int AW       = 8,
  parameter int DW       = 18,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt,
  ir_fetch_if.master    bus,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          fetch_err
);

  typedef enum logic [2:0] {IDLE, FETCH, WRITE, READ, ISSUE} state_t;

  state_t        state, state_nxt;
  logic          run, run_nxt;
  logic          tmo;
  logic [DW-1:0] ir_q;
  logic          handshake;

  assign handshake    = (state == ISSUE) && bus.dec_ready;
  assign bus.mem_addr = pc;
  assign bus.IRin     = ir_q;

  // halt has the last word over start; a timeout also stops the run
  always_comb begin
    run_nxt = run;
    if (start) run_nxt = 1'b1;
    if (halt || tmo) run_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      run   <= 1'b0;
      pc    <= AW'(RESET_PC);
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
      if ((state == FETCH) && bus.mem_ack) ir_q <= bus.mem_data;
      if (handshake) pc <= bus.pc_load ? bus.pc_load_val : pc + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !halt) state_nxt = FETCH;
      FETCH: begin
        if (bus.mem_ack)  state_nxt = WRITE;
        else if (tmo)     state_nxt = IDLE;
      end
      WRITE:   state_nxt = READ;
      READ:    state_nxt = ISSUE;
      ISSUE:   if (bus.dec_ready) state_nxt = run_nxt ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from the state register so reset drops them at once.
  always_comb begin
    bus.mem_rd   = 1'b0;
    bus.wr_IR    = 1'b0;
    bus.re_IR    = 1'b0;
    bus.ir_valid = 1'b0;
    busy         = (state != IDLE);
    case (state)
      FETCH:   bus.mem_rd   = 1'b1;
      WRITE:   bus.wr_IR    = 1'b1;
      READ:    bus.re_IR    = 1'b1;
      ISSUE:   bus.ir_valid = 1'b1;
      default: ;
    endcase
  end

`ifdef IR_FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Expiry on the TIMEOUT-th FETCH cycle; an ack in that cycle still wins.
  assign tmo = (state == FETCH) && !bus.mem_ack && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      wait_cnt <= (state == FETCH) ? wait_cnt + 1'b1 : '0;
      if (tmo)        fetch_err <= 1'b1;
      else if (start) fetch_err <= 1'b0;
    end
  end
`else
  assign tmo       = 1'b0;
  // constant 0: TIMEOUT only has meaning with the timeout counter built in
  assign fetch_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_ir_fetch.sv
// Self-checking bench for ir_fetch: directed steps plus randomized fetch traffic
// against a transaction-level model (PC value, memory image, run flag).
module tb_ir_fetch;
  localparam int AW = 8;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic [AW-1:0] pc;
  logic          busy;
  logic          fetch_err;

  ir_fetch_if #(.AW(AW), .DW(DW)) bus ();

  ir_fetch #(.AW(AW), .DW(DW), .RESET_PC(0), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .halt      (halt),
    .bus       (bus),
    .pc        (pc),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [DW-1:0] mem [256];
  logic [AW-1:0] mpc;
  bit            mrun;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves one cycle after the handshake.
  task automatic do_instr(input int wt, input int rd, input bit ld,
                          input logic [AW-1:0] lv, input bit hw);
    logic [DW-1:0] word;
    chk("fetch_rd", 32'(bus.mem_rd), 1);
    chk("fetch_addr", 32'(bus.mem_addr), 32'(mpc));
    chk("fetch_busy", 32'(busy), 1);
    for (int i = 0; i < wt; i++) begin
      bus.mem_ack  = 1'b0;
      bus.mem_data = DW'($urandom);
      step();
      chk("wait_rd", 32'(bus.mem_rd), 1);
      chk("wait_addr", 32'(bus.mem_addr), 32'(mpc));
    end
    word = mem[mpc];
    bus.mem_ack  = 1'b1;
    bus.mem_data = word;
    step();
    bus.mem_ack     = 1'b0;
    bus.mem_data    = DW'($urandom);
    bus.pc_load     = 1'($urandom);
    bus.pc_load_val = AW'($urandom);
    halt = hw;
    if (hw) mrun = 1'b0;
    chk("wr_IR", 32'(bus.wr_IR), 1);
    chk("wr_re_excl", 32'(bus.re_IR), 0);
    chk("IRin_capture", 32'(bus.IRin), 32'(word));
    chk("wr_mem_rd", 32'(bus.mem_rd), 0);
    step();
    halt = 1'b0;
    chk("re_IR", 32'(bus.re_IR), 1);
    chk("re_wr_excl", 32'(bus.wr_IR), 0);
    chk("IRin_hold", 32'(bus.IRin), 32'(word));
    step();
    chk("ir_valid", 32'(bus.ir_valid), 1);
    chk("issue_re", 32'(bus.re_IR), 0);
    for (int i = 0; i < rd; i++) begin
      bus.dec_ready   = 1'b0;
      bus.pc_load     = 1'($urandom);
      bus.pc_load_val = AW'($urandom);
      step();
      chk("stall_valid", 32'(bus.ir_valid), 1);
      chk("stall_pc", 32'(pc), 32'(mpc));
    end
    bus.dec_ready   = 1'b1;
    bus.pc_load     = ld;
    bus.pc_load_val = lv;
    step();
    mpc = ld ? lv : mpc + 8'd1;
    bus.dec_ready = 1'b0;
    bus.pc_load   = 1'b0;
    chk("next_pc", 32'(pc), 32'(mpc));
    if (mrun) begin
      chk("next_rd", 32'(bus.mem_rd), 1);
      chk("next_addr", 32'(bus.mem_addr), 32'(mpc));
    end else begin
      chk("stop_busy", 32'(busy), 0);
      chk("stop_rd", 32'(bus.mem_rd), 0);
    end
  endtask

  initial begin
    bus.mem_ack     = 1'b0;
    bus.mem_data    = '0;
    bus.dec_ready   = 1'b0;
    bus.pc_load     = 1'b0;
    bus.pc_load_val = '0;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[0] = 18'h2A5C0;
    mpc  = '0;
    mrun = 1'b0;

    step();
    step();
    chk("rst_mem_rd", 32'(bus.mem_rd), 0);
    chk("rst_wr_IR", 32'(bus.wr_IR), 0);
    chk("rst_re_IR", 32'(bus.re_IR), 0);
    chk("rst_ir_valid", 32'(bus.ir_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_IRin", 32'(bus.IRin), 0);
    chk("rst_fetch_err", 32'(fetch_err), 0);
    rst = 1'b1;
    step();

    // first fetch, zero-wait memory, decoder stalls 3 cycles
    start = 1'b1;
    mrun  = 1'b1;
    step();
    start = 1'b0;
    do_instr(0, 3, 1'b0, '0, 1'b0);

    // branch to F0, then to FF, then wrap to 00
    do_instr(1, 0, 1'b1, 8'hF0, 1'b0);
    do_instr(0, 0, 1'b1, 8'hFF, 1'b0);
    do_instr(2, 1, 1'b0, '0, 1'b0);
    chk("wrap_pc", 32'(pc), 0);

    for (int n = 0; n < 20; n++)
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), AW'($urandom), 1'b0);

    // halt during WRITE: instruction completes, then idle
    do_instr(0, 1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_idle_busy", 32'(busy), 0);
      chk("halt_idle_rd", 32'(bus.mem_rd), 0);
    end

    // asynchronous reset in the middle of FETCH
    start = 1'b1;
    mrun  = 1'b1;
    step();
    start = 1'b0;
    chk("pre_arst_rd", 32'(bus.mem_rd), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_rd", 32'(bus.mem_rd), 0);
    chk("arst_wr", 32'(bus.wr_IR), 0);
    chk("arst_re", 32'(bus.re_IR), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_pc", 32'(pc), 0);
    step();
    rst  = 1'b1;
    mpc  = '0;
    step();

    // memory never acknowledges
    start = 1'b1;
    step();
    start = 1'b0;
    bus.mem_ack = 1'b0;
    chk("tmo_start_rd", 32'(bus.mem_rd), 1);
`ifdef IR_FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      step();
      chk("tmo_wait_rd", 32'(bus.mem_rd), 1);
    end
    step();
    chk("tmo_err", 32'(fetch_err), 1);
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_rd", 32'(bus.mem_rd), 0);
    chk("tmo_pc", 32'(pc), 32'(mpc));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("tmo_clear_err", 32'(fetch_err), 0);
`else
    for (int i = 0; i < 100; i++) step();
    chk("notmo_rd", 32'(bus.mem_rd), 1);
    chk("notmo_busy", 32'(busy), 1);
    chk("notmo_err", 32'(fetch_err), 0);
    chk("notmo_pc", 32'(pc), 32'(mpc));
`endif
    do_instr(0, 0, 1'b0, '0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
